ioctl_loader_bridge: RTL and testbench

//  Parametrised successor to the single-channel ldr_wr/ldr_ack/ldr_done loader handshake in the emu top level.

---
 rtl/ioctl_loader_bridge.sv | 150 +++++++++++++++
 tb/tb_ioctl_loader_bridge.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ioctl_loader_bridge.sv
// ioctl_loader_bridge: packs the hps_io ioctl byte stream into big-endian words, queues them,
// and hands them to a core loader port with a held-request / edge-ack handshake.
module ioctl_loader_bridge #(
  parameter int OUT_W = 16,
  parameter int ADDR_W = 20,
  parameter int NCH = 2,
  parameter int IDX_BASE = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int REARM = 0
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ioctl_download,
  input  logic [7:0] ioctl_index,
  input  logic ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0] ioctl_dout,
  output logic ioctl_wait,
  output logic ldr_aen,
  output logic ldr_wr,
  output logic [ADDR_W-1:0] ldr_addr,
  output logic [OUT_W-1:0] ldr_wdat,
  output logic [OUT_W/8-1:0] ldr_be,
  output logic [(NCH>1?$clog2(NCH):1)-1:0] ldr_ch,
  input  logic ldr_ack,
  output logic [NCH-1:0] ldr_done,
  output logic err_ovf
);
  localparam int B = OUT_W / 8;
  localparam int LW = B > 1 ? $clog2(B) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [B-1:0] be;
    logic [OUT_W-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  state_t state, state_n;
  logic dl_q, ack_q, pop, ld, jump, full, pa_v, pb_v, ovf;
  logic [CW-1:0] ch, ch_n, c_hit;
  logic [NCH-1:0] done_clr, done_set;
  logic [ADDR_W-1:0] pk_addr, wa;
  logic [B-1:0] pk_be, nbe;
  logic [OUT_W-1:0] pk_dat, nd;
  logic [LW-1:0] lane;
  logic [1:0] n, acc;
  logic [PW:0] count, count_n;
  logic [PW+1:0] space;
  logic [PW-1:0] rp, wp;
  ent_t mem [FIFO_DEPTH];
  ent_t e_pack, e_new, s0, head;
  int idx_rel, sh;
  logic unused_addr;
  assign unused_addr = ^ioctl_addr[24:ADDR_W];
  always_comb begin
    state_n = state;
    ch_n = ch;
    done_clr = '0;
    done_set = '0;
    idx_rel = int'(ioctl_index) - IDX_BASE;
    c_hit = CW'(idx_rel);
    case (state)
      IDLE:
        if (ioctl_download && !dl_q && idx_rel >= 0 && idx_rel < NCH && (!ldr_done[c_hit] || REARM != 0)) begin
          state_n = LOAD;
          ch_n = c_hit;
          done_clr[c_hit] = 1'b1;
        end
      LOAD: state_n = ioctl_download ? LOAD : FLUSH;
      FLUSH: state_n = DRAIN;
      default:
        if (count == 0) begin
          state_n = IDLE;
          done_set[ch] = 1'b1;
        end
    endcase
  end
  // Packing: a byte may both flush the previous (different-address) pack and complete a new word.
  always_comb begin
    wa = ioctl_addr[ADDR_W-1:0] & ~ADDR_W'(B - 1);
    lane = B > 1 ? ioctl_addr[LW-1:0] : '0;
    sh = B - 1 - int'(lane);
    full = int'(lane) == B - 1;
    jump = |pk_be && wa != pk_addr;
    nd = jump ? '0 : pk_dat;
    nd[sh*8 +: 8] = ioctl_dout;
    nbe = (jump ? '0 : pk_be) | (B'(1) << sh);
    ld = state == LOAD && ioctl_wr;
    pa_v = (ld && jump) || (state == FLUSH && |pk_be);
    pb_v = ld && full;
    n = 2'(pa_v) + 2'(pb_v);
    pop = ldr_wr && ldr_ack && !ack_q;
    space = (PW+2)'(FIFO_DEPTH) - (PW+2)'(count) + (PW+2)'(pop);
    ovf = (PW+2)'(n) > space;
    acc = ovf ? space[1:0] : n;
    count_n = count + (PW+1)'(acc) - (PW+1)'(pop);
    e_pack = '{pk_addr, pk_be, pk_dat, ch};
    e_new = '{wa, nbe, nd, ch};
    s0 = pa_v ? e_pack : e_new;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ch <= '0;
      dl_q <= 1'b0;
      ack_q <= 1'b0;
      ldr_done <= '0;
      err_ovf <= 1'b0;
      count <= '0;
      rp <= '0;
      wp <= '0;
      ioctl_wait <= 1'b0;
      pk_addr <= '0;
      pk_be <= '0;
      pk_dat <= '0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      dl_q <= ioctl_download;
      ack_q <= ldr_ack;
      ldr_done <= (ldr_done & ~done_clr) | done_set;
      err_ovf <= err_ovf | ovf;
      count <= count_n;
      rp <= rp + PW'(pop);
      wp <= wp + PW'(acc);
      ioctl_wait <= count_n >= (PW+1)'(FIFO_DEPTH - 1);
      if (ld && full || state == FLUSH) begin
        pk_be <= '0;
        pk_dat <= '0;
      end else if (ld) begin
        pk_be <= nbe;
        pk_dat <= nd;
        pk_addr <= wa;
      end
    end
  end
  always_ff @(posedge clk_sys) begin
    if (acc != 0) mem[wp] <= s0;
    if (acc == 2) mem[wp + PW'(1)] <= e_new;
  end
  assign head = mem[rp];
  assign ldr_wr = count != 0;
  assign ldr_aen = state != IDLE;
  assign ldr_addr = ldr_wr ? head.a : '0;
  assign ldr_wdat = ldr_wr ? head.d : '0;
  assign ldr_be = ldr_wr ? head.be : '0;
  assign ldr_ch = ldr_wr ? head.c : '0;
endmodule

// File: tb/tb_ioctl_loader_bridge.sv
// tb_ioctl_loader_bridge: table of downloads plus hand sequences for reset, backpressure and overflow;
// expected loader words go into a scoreboard queue and are checked when the bench acks them.
module tb_ioctl_loader_bridge;
  logic clk = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0, ldr_ack = 0, ack_r = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0;
  logic [24:0] ioctl_addr = 0;
  logic ioctl_wait, ldr_aen, ldr_wr, err_ovf;
  logic [19:0] ldr_addr;
  logic [15:0] ldr_wdat;
  logic [1:0] ldr_be, ldr_done;
  logic [0:0] ldr_ch;
  logic wait_r, aen_r, wr_r, ovf_r;
  logic [19:0] addr_r;
  logic [15:0] wdat_r;
  logic [1:0] be_r, done_r;
  logic [0:0] ch_r;
  typedef struct packed {logic [19:0] a; logic [15:0] d; logic [1:0] be; logic c;} exp_t;
  typedef struct {int idx; int n; int a0; int d0; bit act; bit mid_r0; bit [1:0] done; bit [1:0] done_r;} row_t;
  exp_t q[$];
  row_t rows[4];
  int tests = 0, fails = 0, wr_seen = 0;
  bit ack_en = 1;

  ioctl_loader_bridge dut (.clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .ldr_aen(ldr_aen),
    .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdat(ldr_wdat), .ldr_be(ldr_be), .ldr_ch(ldr_ch), .ldr_ack(ldr_ack),
    .ldr_done(ldr_done), .err_ovf(err_ovf));
  ioctl_loader_bridge #(.REARM(1)) dut_r (.clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wait_r), .ldr_aen(aen_r), .ldr_wr(wr_r), .ldr_addr(addr_r), .ldr_wdat(wdat_r), .ldr_be(be_r),
    .ldr_ch(ch_r), .ldr_ack(ack_r), .ldr_done(done_r), .err_ovf(ovf_r));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Main loader: ack two cycles after ldr_wr is seen, checking the presented word first.
  initial forever begin
    @(negedge clk);
    if (ack_en && ldr_wr) begin
      @(negedge clk);
      @(negedge clk);
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) chk("word", {ldr_addr, ldr_wdat, ldr_be, ldr_ch}, q.pop_front());
      ldr_ack = 1;
      @(negedge clk);
      ldr_ack = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    ack_r = wr_r & ~ack_r;
  end
  always @(negedge clk) if (ldr_wr) wr_seen++;

  task automatic send(input int a, input int d, input bit honour);
    int t = 0;
    while (honour && ioctl_wait && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bound", t < 200, 1);
    ioctl_addr = 25'(a);
    ioctl_dout = 8'(d);
    ioctl_wr = 1;
    @(negedge clk);
    ioctl_wr = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((ldr_aen || aen_r) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("idle_bound", t < 400, 1);
  endtask

  task automatic expect_bytes(input int a0, input int n, input int d0, input int c);
    for (int w = a0 & ~1; w <= a0 + n - 1; w += 2) begin
      bit hi = w >= a0, lo = w + 1 <= a0 + n - 1;
      q.push_back({20'(w), hi ? 8'(d0 + w - a0) : 8'h00, lo ? 8'(d0 + w + 1 - a0) : 8'h00, hi, lo, 1'(c)});
    end
  endtask

  initial begin
    rows[0] = '{idx: 0, n: 6, a0: 0, d0: 'h00, act: 1, mid_r0: 0, done: 2'b01, done_r: 2'b01};
    rows[1] = '{idx: 1, n: 3, a0: 0, d0: 'hAA, act: 1, mid_r0: 1, done: 2'b11, done_r: 2'b11};
    rows[2] = '{idx: 0, n: 4, a0: 8, d0: 'h40, act: 0, mid_r0: 0, done: 2'b11, done_r: 2'b11};
    rows[3] = '{idx: 7, n: 2, a0: 0, d0: 'h70, act: 0, mid_r0: 1, done: 2'b11, done_r: 2'b11};
    repeat (2) @(negedge clk);
    chk("reset_outs", {ioctl_wait, ldr_aen, ldr_wr, ldr_addr, ldr_wdat, ldr_be, ldr_ch, ldr_done, err_ovf}, 0);
    reset = 0;
    @(negedge clk);
    foreach (rows[i]) begin
      wr_seen = 0;
      if (rows[i].act) expect_bytes(rows[i].a0, rows[i].n, rows[i].d0, rows[i].idx);
      ioctl_index = 8'(rows[i].idx);
      ioctl_download = 1;
      repeat (2) @(negedge clk);
      chk("mid_done_r0", done_r[0], rows[i].mid_r0);
      for (int b = 0; b < rows[i].n; b++) send(rows[i].a0 + b, rows[i].d0 + b, 1);
      ioctl_download = 0;
      @(negedge clk);
      wait_idle();
      chk("done", ldr_done, rows[i].done);
      chk("done_r", done_r, rows[i].done_r);
      chk("active", wr_seen != 0, rows[i].act);
      chk("sb_drained", q.size(), 0);
    end
    // Reset in the middle of a load with a request pending.
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("done_cleared", ldr_done, 0);
    ack_en = 0;
    ioctl_index = 0;
    ioctl_download = 1;
    repeat (2) @(negedge clk);
    send(0, 'h11, 0);
    send(1, 'h22, 0);
    chk("pending_wr", ldr_wr, 1);
    #2 reset = 1;
    ioctl_download = 0;
    #1 chk("async_reset", {ioctl_wait, ldr_aen, ldr_wr, ldr_addr, ldr_wdat, ldr_be, ldr_ch, ldr_done, err_ovf}, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    // Backpressure with acks withheld.
    expect_bytes(0, 6, 'h10, 0);
    ioctl_download = 1;
    repeat (2) @(negedge clk);
    for (int b = 0; b < 4; b++) send(b, 'h10 + b, 0);
    chk("wait_two", ioctl_wait, 0);
    send(4, 'h14, 0);
    send(5, 'h15, 0);
    chk("wait_three", ioctl_wait, 1);
    chk("wr_held", ldr_wr, 1);
    ack_en = 1;
    for (int t = 0; t < 200 && ldr_wr; t++) @(negedge clk);
    chk("wait_released", ioctl_wait, 0);
    ioctl_download = 0;
    @(negedge clk);
    wait_idle();
    chk("bp_done", ldr_done, 2'b01);
    chk("bp_ovf", err_ovf, 0);
    chk("bp_drained", q.size(), 0);
    // Address jumps fill the FIFO; the bytes that ignore wait are dropped.
    ack_en = 0;
    for (int k = 0; k < 4; k++) q.push_back({20'(k * 'h10), 8'('hAA + k * 'h11), 8'h00, 2'b10, 1'b1});
    ioctl_index = 1;
    ioctl_download = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) send(k * 'h10, 'hAA + k * 'h11, 0);
    chk("ovf_before", err_ovf, 0);
    send('h50, 'hFF, 0);
    chk("ovf_after", err_ovf, 1);
    ioctl_download = 0;
    repeat (3) @(negedge clk);
    ack_en = 1;
    wait_idle();
    chk("ovf_done", ldr_done, 2'b11);
    chk("ovf_drained", q.size(), 0);
    chk("ovf_sticky", err_ovf, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
